// File: rtl/arb_tl_mpu_subsys.sv
// arb_tl_mpu_subsys: age-based arbiter over per-core TL-A requests, feeding a
// request FIFO that drains into a two-state memory protection unit. The MPU
// reserves runs of contiguous blocks per core, frees them, and performs
// owner-checked word reads/writes.
module arb_tl_mpu_subsys #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned AGE_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_BLOCKS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Per core, MSB first: {opcode[2:0], param[2:0], address[31:0], data[31:0],
  // source[3:0], valid, ready}, 76 bits; core 0 in the least significant slot.
  input  logic [NUM_CORES*76-1:0]   req,
  output logic [NUM_CORES-1:0]      ack,
  output logic                      resp_valid,
  output logic [3:0]                resp_source,
  output logic [31:0]               resp_data,
  output logic [1:0]                resp_err
);

  localparam int unsigned CH_W   = 76;
  localparam int unsigned WORDS  = NUM_BLOCKS * 4;
  localparam int unsigned WIDX   = $clog2(WORDS);
  localparam int unsigned BIDX   = $clog2(NUM_BLOCKS);
  localparam int unsigned ADDR_W = (WIDX > 5) ? WIDX : 5;
  localparam int unsigned CIDX   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UNU_W  = 40 - ADDR_W;

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_NO_SPACE = 2'd1,
    ERR_PERM     = 2'd2,
    ERR_BAD_SIZE = 2'd3
  } err_t;

  // Channel fields
  logic [2:0]                 ch_op   [NUM_CORES];
  logic [ADDR_W-1:0]          ch_addr [NUM_CORES];
  logic [31:0]                ch_data [NUM_CORES];
  logic [NUM_CORES-1:0]       ch_valid;
  logic [NUM_CORES*UNU_W-1:0] unused_fields;

  // Arbiter
  logic [AGE_WIDTH-1:0] age_q [NUM_CORES];
  logic                 win_found;
  logic [CIDX-1:0]      win_idx;
  logic [AGE_WIDTH-1:0] best_age;
  logic                 grant;

  // Request FIFO
  logic [2:0]        fifo_op_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic [3:0]        fifo_src_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fifo_full;
  logic              deq;

  // MPU
  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        src_q;
  logic [NUM_BLOCKS-1:0] own_vld_q;
  logic [3:0]        own_id_q [NUM_BLOCKS];
  logic [31:0]       mem_q [WORDS];

  logic              cfg, we, rsv;
  logic [4:0]        size;
  logic              size_bad;
  logic              fit_found;
  logic [BIDX-1:0]   fit_base;
  logic              run_ok;
  logic [WIDX-1:0]   word_idx;
  logic [BIDX-1:0]   blk_idx;
  logic              perm;
  logic              rsv_ok, do_free, do_write;
  logic [31:0]       rsp_data_d;
  err_t              rsp_err_d;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign ch_op[g]    = req[g*CH_W+73 +: 3];
    assign ch_addr[g]  = req[g*CH_W+38 +: ADDR_W];
    assign ch_data[g]  = req[g*CH_W+6 +: 32];
    assign ch_valid[g] = req[g*CH_W+1];
    assign unused_fields[g*UNU_W +: UNU_W] = {req[g*CH_W+70 +: 3],
                                              req[g*CH_W+38+ADDR_W +: (32-ADDR_W)],
                                              req[g*CH_W+2 +: 4], req[g*CH_W]};
  end

  // Winner: oldest valid core; strict compare keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    best_age  = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (ch_valid[i] && (!win_found || age_q[i] > best_age)) begin
        win_found = 1'b1;
        win_idx   = CIDX'(i);
        best_age  = age_q[i];
      end
    end
  end

  assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign grant     = win_found && !fifo_full && !rst_n;
  assign deq       = (cnt_q != '0) && (state_q == S_IDLE);

  // One-hot grant pulse for the cycle the winner is enqueued.
  always_comb begin
    ack = '0;
    if (grant) ack[win_idx] = 1'b1;
  end

  // Saturating wait-age per core; cleared on grant or when not requesting.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (rst_n || !ch_valid[i] || ack[i]) age_q[i] <= '0;
      else if (age_q[i] != '1)             age_q[i] <= age_q[i] + 1'b1;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // FIFO pointers and occupancy; a full FIFO never grants, so a same-cycle
  // dequeue cannot make room for the current winner.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (grant) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (deq)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (grant && !deq)      cnt_q <= cnt_q + 1'b1;
      else if (!grant && deq) cnt_q <= cnt_q - 1'b1;
    end
  end

  // FIFO payload and MPU operand latch (no reset needed on data).
  always_ff @(posedge clk) begin
    if (grant) begin
      fifo_op_q[wr_ptr_q]   <= ch_op[win_idx];
      fifo_addr_q[wr_ptr_q] <= ch_addr[win_idx];
      fifo_data_q[wr_ptr_q] <= ch_data[win_idx];
      fifo_src_q[wr_ptr_q]  <= 4'(win_idx);
    end
    if (deq) begin
      op_q   <= fifo_op_q[rd_ptr_q];
      addr_q <= fifo_addr_q[rd_ptr_q];
      data_q <= fifo_data_q[rd_ptr_q];
      src_q  <= fifo_src_q[rd_ptr_q];
    end
  end

  // MPU state register.
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // MPU next state: IDLE takes the FIFO head, EXEC always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cnt_q != '0) state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg      = op_q[0];
  assign we       = op_q[1];
  assign rsv      = op_q[2];
  assign size     = addr_q[4:0];
  assign size_bad = (size == '0) || (32'(size) > NUM_BLOCKS);
  assign word_idx = addr_q[WIDX-1:0];
  assign blk_idx  = addr_q[WIDX-1:2];
  assign perm     = own_vld_q[blk_idx] && (own_id_q[blk_idx] == src_q);
  assign rsv_ok   = (state_q == S_EXEC) && cfg && rsv && !size_bad && fit_found;
  assign do_free  = (state_q == S_EXEC) && cfg && !rsv;
  assign do_write = (state_q == S_EXEC) && !cfg && we && perm && !rst_n;

  // First-fit search over the free map and response formation.
  always_comb begin
    fit_found  = 1'b0;
    fit_base   = '0;
    run_ok     = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = ERR_NONE;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      run_ok = (b + 32'(size) <= NUM_BLOCKS);
      for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
        if (k >= b && k < b + 32'(size) && own_vld_q[k]) run_ok = 1'b0;
      end
      if (run_ok && !fit_found) begin
        fit_found = 1'b1;
        fit_base  = BIDX'(b);
      end
    end
    if (cfg) begin
      if (rsv) begin
        if (size_bad)        rsp_err_d  = ERR_BAD_SIZE;
        else if (!fit_found) rsp_err_d  = ERR_NO_SPACE;
        else                 rsp_data_d = 32'(fit_base);
      end
    end else if (!perm) begin
      rsp_err_d = ERR_PERM;
    end else if (!we) begin
      rsp_data_d = mem_q[word_idx];
    end
  end

  // Block ownership table.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      own_vld_q <= '0;
      for (int unsigned k = 0; k < NUM_BLOCKS; k++) own_id_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
        if (rsv_ok && k >= 32'(fit_base) && k < 32'(fit_base) + 32'(size)) begin
          own_vld_q[k] <= 1'b1;
          own_id_q[k]  <= src_q;
        end else if (do_free && own_vld_q[k] && own_id_q[k] == src_q) begin
          own_vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Protected data memory; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[word_idx] <= data_q;
  end

  // Registered response, one cycle after the EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      resp_valid  <= 1'b0;
      resp_source <= '0;
      resp_data   <= '0;
      resp_err    <= '0;
    end else begin
      resp_valid <= (state_q == S_EXEC);
      if (state_q == S_EXEC) begin
        resp_source <= src_q;
        resp_data   <= rsp_data_d;
        resp_err    <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_arb_tl_mpu_subsys.sv
// Testbench for arb_tl_mpu_subsys: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_arb_tl_mpu_subsys;
  localparam int NC = 4;
  localparam int DEPTH = 4;
  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC*76-1:0] req;
  logic [NC-1:0]   ack;
  logic            resp_valid;
  logic [3:0]      resp_source;
  logic [31:0]     resp_data;
  logic [1:0]      resp_err;

  always #5 clk = ~clk;

  arb_tl_mpu_subsys #(
    .NUM_CORES(NC), .AGE_WIDTH(8), .FIFO_DEPTH(DEPTH), .NUM_BLOCKS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .resp_valid(resp_valid),
    .resp_source(resp_source), .resp_data(resp_data), .resp_err(resp_err)
  );

  int checks = 0;
  int errors = 0;

  // Requester side
  logic [2:0]  r_op   [NC];
  logic [31:0] r_addr [NC];
  logic [31:0] r_data [NC];
  logic [3:0]  r_src  [NC];
  logic        r_valid[NC];
  bit          auto_drop[NC];

  // Reference model
  typedef struct {logic [2:0] op; logic [31:0] addr; logic [31:0] data; int src;} ent_t;
  ent_t        mq[$];
  bit          mx_v;
  ent_t        mx_e;
  int          age[NC];
  int          owner[NB];
  logic [31:0] mem[64];
  bit          written[64];
  bit          rv;
  int          rsrc;
  logic [31:0] rdata;
  int          rerr;
  bit          rdata_known;
  bit          live = 1'b0;

  typedef struct {int src; logic [31:0] data; int err;} obs_t;
  obs_t obs_log[$];
  int   grant_log[$];
  int   stall_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_req();
    for (int i = 0; i < NC; i++)
      req[i*76 +: 76] = {r_op[i], 3'b101, r_addr[i], r_data[i], r_src[i], r_valid[i], 1'b1};
  endtask

  function automatic void model_reset();
    mq.delete();
    mx_v = 1'b0;
    for (int i = 0; i < NC; i++) age[i] = 0;
    for (int k = 0; k < NB; k++) owner[k] = -1;
    rv = 1'b0; rsrc = 0; rdata = '0; rerr = 0; rdata_known = 1'b1;
    live = 1'b1;
  endfunction

  function automatic int model_winner();
    int best = -1;
    if (rst_n || mq.size() >= DEPTH) return -1;
    for (int i = 0; i < NC; i++)
      if (r_valid[i] === 1'b1 && (best < 0 || age[i] > age[best])) best = i;
    return best;
  endfunction

  function automatic void exec_model(ent_t e);
    int size, base, w, blk;
    rsrc = e.src; rdata = '0; rerr = 0; rdata_known = 1'b1;
    if (e.op[0] && e.op[2]) begin
      size = int'(e.addr[4:0]);
      if (size == 0 || size > NB) rerr = 3;
      else begin
        base = -1;
        for (int b = 0; b + size <= NB && base < 0; b++) begin
          bit ok;
          ok = 1'b1;
          for (int k = b; k < b + size; k++) if (owner[k] >= 0) ok = 1'b0;
          if (ok) base = b;
        end
        if (base < 0) rerr = 1;
        else begin
          for (int k = base; k < base + size; k++) owner[k] = e.src;
          rdata = 32'(base);
        end
      end
    end else if (e.op[0]) begin
      for (int k = 0; k < NB; k++) if (owner[k] == e.src) owner[k] = -1;
    end else begin
      w   = int'(e.addr[5:0]);
      blk = int'(e.addr[5:2]);
      if (owner[blk] != e.src) rerr = 2;
      else if (e.op[1]) begin
        mem[w] = e.data; written[w] = 1'b1;
      end else begin
        rdata = mem[w]; rdata_known = written[w];
      end
    end
  endfunction

  function automatic void model_edge(int w);
    bit nrv;
    if (rst_n) begin
      model_reset();
      return;
    end
    nrv = mx_v;
    if (mx_v) begin
      exec_model(mx_e);
      mx_v = 1'b0;
    end else if (mq.size() > 0) begin
      mx_e = mq.pop_front();
      mx_v = 1'b1;
    end
    if (w >= 0) mq.push_back('{r_op[w], r_addr[w], r_data[w], w});
    rv = nrv;
    for (int i = 0; i < NC; i++) begin
      if (r_valid[i] !== 1'b1 || i == w) age[i] = 0;
      else if (age[i] < 255) age[i]++;
    end
  endfunction

  task automatic step();
    int w, gi;
    bit allv;
    apply_req();
    #2;
    w = model_winner();
    if (live) begin
      check("ack", ack, (w < 0) ? 32'd0 : (32'd1 << w));
      check("resp_valid", resp_valid, rv);
      if (rv) begin
        check("resp_source", resp_source, rsrc);
        check("resp_err", resp_err, rerr);
        if (rdata_known) check("resp_data", resp_data, rdata);
      end
    end
    if (resp_valid === 1'b1) obs_log.push_back('{int'(resp_source), resp_data, int'(resp_err)});
    gi = -1;
    for (int i = NC - 1; i >= 0; i--) if (ack[i] === 1'b1) gi = i;
    if (gi >= 0) grant_log.push_back(gi);
    allv = 1'b1;
    for (int i = 0; i < NC; i++) if (r_valid[i] !== 1'b1) allv = 1'b0;
    if (allv && !rst_n && ack === '0) stall_cnt++;
    @(posedge clk);
    model_edge(w);
    @(negedge clk);
    if (w >= 0 && auto_drop[w]) r_valid[w] = 1'b0;
  endtask

  task automatic issue(input int c, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data);
    r_op[c] = op; r_addr[c] = addr; r_data[c] = data;
    r_src[c] = 4'($urandom); r_valid[c] = 1'b1; auto_drop[c] = 1'b1;
  endtask

  task automatic run_idle(input int limit);
    bit busy;
    for (int n = 0; n < limit; n++) begin
      busy = mx_v || rv || (mq.size() > 0);
      for (int i = 0; i < NC; i++) if (r_valid[i] === 1'b1) busy = 1'b1;
      if (!busy) break;
      step();
    end
  endtask

  task automatic clear_logs();
    obs_log.delete();
    grant_log.delete();
  endtask

  initial begin
    logic [31:0] a;
    logic        hi;
    int          k;
    for (int i = 0; i < NC; i++) begin
      r_op[i] = '0; r_addr[i] = '0; r_data[i] = '0; r_src[i] = '0;
      r_valid[i] = 1'b0; auto_drop[i] = 1'b1;
    end
    for (int j = 0; j < 64; j++) begin mem[j] = '0; written[j] = 1'b0; end
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #2;
    check("rst_ack", ack, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_source", resp_source, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    @(negedge clk);

    // Two reserves issued together
    clear_logs();
    issue(0, 3'b101, 32'd4, 32'd0);
    issue(1, 3'b101, 32'd6, 32'd0);
    run_idle(40);
    check("r030_nresp", obs_log.size(), 2);
    check("r030_grant0", grant_log[0], 0);
    check("r030_grant1", grant_log[1], 1);
    check("r030_src0", obs_log[0].src, 0);
    check("r030_base0", obs_log[0].data, 0);
    check("r030_err0", obs_log[0].err, 0);
    check("r030_src1", obs_log[1].src, 1);
    check("r030_base1", obs_log[1].data, 4);
    check("r030_err1", obs_log[1].err, 0);

    // Owner write then read
    clear_logs();
    issue(0, 3'b010, 32'd0, 32'h0000_FFFF);
    run_idle(40);
    issue(0, 3'b000, 32'd0, 32'd0);
    run_idle(40);
    check("r031_nresp", obs_log.size(), 2);
    check("r031_wr_err", obs_log[0].err, 0);
    check("r031_rd_err", obs_log[1].err, 0);
    check("r031_rd_data", obs_log[1].data, 32'h0000_FFFF);

    // Foreign read is refused
    clear_logs();
    issue(1, 3'b000, 32'd0, 32'd0);
    run_idle(40);
    check("r032_err", obs_log[0].err, 2);
    check("r032_data", obs_log[0].data, 0);

    // Reserve too large for remaining space, and size zero
    clear_logs();
    issue(2, 3'b101, 32'd7, 32'd0);
    run_idle(40);
    issue(2, 3'b101, 32'd0, 32'd0);
    run_idle(40);
    check("r033_nresp", obs_log.size(), 2);
    check("r033_nospace", obs_log[0].err, 1);
    check("r033_badsize", obs_log[1].err, 3);

    // Free then read back
    clear_logs();
    issue(0, 3'b001, 32'd0, 32'd0);
    run_idle(40);
    issue(0, 3'b000, 32'd0, 32'd0);
    run_idle(40);
    check("r035_free_err", obs_log[0].err, 0);
    check("r035_read_err", obs_log[1].err, 2);

    // All cores requesting continuously
    clear_logs();
    stall_cnt = 0;
    for (int i = 0; i < NC; i++) begin
      issue(i, 3'b000, 32'(i * 4), 32'd0);
      auto_drop[i] = 1'b0;
    end
    for (int n = 0; n < 24; n++) step();
    check("r034_order0", grant_log[0], 0);
    check("r034_order1", grant_log[1], 1);
    check("r034_order2", grant_log[2], 2);
    check("r034_order3", grant_log[3], 3);
    check("r034_full_stall", (stall_cnt > 0), 1);
    for (int i = 0; i < NC; i++) r_valid[i] = 1'b0;
    run_idle(60);

    // Reset in the middle of execution discards everything
    issue(1, 3'b101, 32'd3, 32'd0);
    issue(2, 3'b101, 32'd2, 32'd0);
    issue(3, 3'b101, 32'd2, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NC; i++) r_valid[i] = 1'b0;
    step();
    rst_n = 1'b0;
    clear_logs();
    for (int n = 0; n < 8; n++) step();
    check("r029_no_resp", obs_log.size(), 0);

    // Random traffic with a mid-run reset
    for (int c = 0; c < 600; c++) begin
      if (c == 300) rst_n = 1'b1;
      if (c == 302) rst_n = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (r_valid[i] !== 1'b1 && $urandom_range(0, 2) == 0) begin
          k  = $urandom_range(0, 9);
          hi = 1'($urandom);
          a  = $urandom;
          if (k < 3) begin
            a[4:0] = 5'($urandom_range(0, 18));
            issue(i, {1'b1, hi, 1'b1}, a, $urandom);
          end else if (k == 3) issue(i, {1'b0, hi, 1'b1}, a, $urandom);
          else if (k < 7)      issue(i, {hi, 2'b10}, a, $urandom);
          else                 issue(i, {hi, 2'b00}, a, $urandom);
        end
      end
      step();
    end
    for (int i = 0; i < NC; i++) r_valid[i] = 1'b0;
    run_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
